cpu_datapath: RTL and testbench

Bus-based 32-bit processor datapath. It contains the register file, PC, IR, MAR, MDR, HI/LO, Y/Z, ALU, CON flip-flop, I/O ports and a 512-word RAM. All transfers use one shared 32-bit bus driven by one-hot `*out` strobes and captured by `*_enable`/`*In` strobes. An external control unit, or a testbench, sequences every micro-step.

---
 rtl/cpu_datapath_if.sv | 35 +++
 rtl/cpu_datapath.sv | 156 +++++++++++++++
 tb/tb_cpu_datapath.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_datapath_if.sv
// Control strobes and data ports of the bus-based datapath, grouped for the
// external sequencer (master) and the datapath itself (slave).
interface cpu_datapath_if;
   logic        IncPC, CONin;
   logic        RAM_write, MDR_enable, MDRout, MAR_enable, IR_enable, MDR_read;
   logic        Gra, Grb, Grc;
   logic        HI_enable, LO_enable, ZHighIn, ZLowIn, Y_enable, PC_enable, OutPort_enable;
   logic        InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, BAout, Cout;
   logic        R_in, R_out, Cin;
   logic [31:0] InPort_input;
   logic [31:0] Mdatain;
   logic [31:0] OutPort_output;

   modport master (
      output IncPC, CONin,
      output RAM_write, MDR_enable, MDRout, MAR_enable, IR_enable, MDR_read,
      output Gra, Grb, Grc,
      output HI_enable, LO_enable, ZHighIn, ZLowIn, Y_enable, PC_enable, OutPort_enable,
      output InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, BAout, Cout,
      output R_in, R_out, Cin,
      output InPort_input, Mdatain,
      input  OutPort_output
   );

   modport slave (
      input  IncPC, CONin,
      input  RAM_write, MDR_enable, MDRout, MAR_enable, IR_enable, MDR_read,
      input  Gra, Grb, Grc,
      input  HI_enable, LO_enable, ZHighIn, ZLowIn, Y_enable, PC_enable, OutPort_enable,
      input  InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, BAout, Cout,
      input  R_in, R_out, Cin,
      input  InPort_input, Mdatain,
      output OutPort_output
   );
endinterface

// File: rtl/cpu_datapath.sv
// 32-bit single-bus processor datapath: register file, PC/IR/MAR/MDR, HI/LO,
// Y/Z with a 64-bit ALU, CON branch flag, I/O ports and a 512-word RAM.
module cpu_datapath (
   input logic          Clock,
   input logic          Clear,
   cpu_datapath_if.slave io
);
   localparam logic [4:0] OP_LDW  = 5'b00000;
   localparam logic [4:0] OP_LDWI = 5'b00001;
   localparam logic [4:0] OP_STW  = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_ANDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01101;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_NEG  = 5'b10000;
   localparam logic [4:0] OP_NOT  = 5'b10001;
   localparam logic [4:0] OP_BR   = 5'b10010;

   logic [31:0] regs [16];
   logic [31:0] ram  [512];
   logic [31:0] pc, ir, mar, mdr, hi, lo, y, in_port, out_port;
   logic [63:0] z;
   logic        con;

   logic [4:0]  opcode;
   logic [3:0]  sel;
   logic [31:0] sel_val, c_sext, bus;
   logic        con_next;

   logic signed [31:0] a_s, b_s, quot, rem;
   logic signed [63:0] a_w, b_w, prod;
   logic [63:0] rot_r, rot_l;
   logic [63:0] result;

   assign opcode  = ir[31:27];
   assign sel     = (io.Gra ? ir[26:23] : 4'd0) |
                    (io.Grb ? ir[22:19] : 4'd0) |
                    (io.Grc ? ir[18:15] : 4'd0);
   assign sel_val = regs[sel];
   assign c_sext  = {{13{ir[18]}}, ir[18:0]};

   assign io.OutPort_output = out_port;

   // Single shared bus; fixed priority resolves accidental multiple drivers.
   always_comb begin
      bus = '0;
      if (io.R_out)          bus = sel_val;
      else if (io.BAout)     bus = (sel == 4'd0) ? 32'd0 : sel_val;
      else if (io.PCout)     bus = pc;
      else if (io.MDRout)    bus = mdr;
      else if (io.ZHighout)  bus = z[63:32];
      else if (io.ZLowout)   bus = z[31:0];
      else if (io.HIout)     bus = hi;
      else if (io.LOout)     bus = lo;
      else if (io.InPortout) bus = in_port;
      else if (io.Cout)      bus = c_sext;
      else if (io.Yout)      bus = y;
   end

   always_comb begin
      case (ir[20:19])
         2'b00:   con_next = (bus == 32'd0);
         2'b01:   con_next = (bus != 32'd0);
         2'b10:   con_next = ~bus[31];
         default: con_next = bus[31];
      endcase
   end

   assign a_s   = y;
   assign b_s   = bus;
   assign a_w   = {{32{y[31]}}, y};
   assign b_w   = {{32{bus[31]}}, bus};
   assign prod  = a_w * b_w;
   assign rot_r = {y, y} >> bus[4:0];
   assign rot_l = {y, y} << bus[4:0];

   // Division by zero is defined rather than left to the simulator.
   always_comb begin
      quot = '0;
      rem  = a_s;
      if (b_s != 32'sd0) begin
         quot = a_s / b_s;
         rem  = a_s % b_s;
      end
   end

   always_comb begin
      result = {32'd0, bus};
      case (opcode)
         OP_ADD, OP_ADDI, OP_LDW, OP_LDWI, OP_STW, OP_BR:
                         result = {32'd0, y + bus};
         OP_SUB:         result = {32'd0, y - bus};
         OP_SHR:         result = {32'd0, y >> bus[4:0]};
         OP_SHL:         result = {32'd0, y << bus[4:0]};
         OP_ROR:         result = {32'd0, rot_r[31:0]};
         OP_ROL:         result = {32'd0, rot_l[63:32]};
         OP_AND, OP_ANDI: result = {32'd0, y & bus};
         OP_OR, OP_ORI:  result = {32'd0, y | bus};
         OP_MUL:         result = prod;
         OP_DIV:         result = {rem, quot};
         OP_NEG:         result = {32'd0, 32'd0 - bus};
         OP_NOT:         result = {32'd0, ~bus};
         default:        result = {32'd0, bus};
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Clear) begin
         for (int i = 0; i < 16; i++) regs[i] <= '0;
         pc       <= '0;
         ir       <= '0;
         mar      <= '0;
         mdr      <= '0;
         hi       <= '0;
         lo       <= '0;
         y        <= '0;
         z        <= '0;
         in_port  <= '0;
         out_port <= '0;
         con      <= 1'b0;
      end else begin
         if (io.R_in)           regs[sel] <= bus;
         if (io.IncPC)          pc <= pc + 32'd1;
         else if (io.PC_enable && ((opcode != OP_BR) || con))
                                pc <= bus;
         if (io.IR_enable)      ir <= bus;
         if (io.MAR_enable)     mar <= bus;
         if (io.MDR_enable)     mdr <= io.MDR_read ? ram[mar[8:0]] : bus;
         if (io.HI_enable)      hi <= bus;
         if (io.LO_enable)      lo <= bus;
         if (io.Y_enable)       y <= bus;
         if (io.ZLowIn)         z[31:0] <= result[31:0];
         if (io.ZHighIn)        z[63:32] <= result[63:32];
         if (io.OutPort_enable) out_port <= bus;
         if (io.CONin)          con <= con_next;
         in_port <= io.InPort_input;
      end
   end

   // RAM contents survive Clear; only the write itself is suppressed.
   always_ff @(posedge Clock) begin
      if (io.RAM_write && !Clear) ram[mar[8:0]] <= mdr;
   end

   logic unused_bits;
   assign unused_bits = ^{io.Mdatain, io.Cin, mar[31:9], rot_r[63:32], rot_l[31:0]};
endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: register contents are observed by routing them over
// the bus into the output port, checked against a scoreboard of expected values.
module tb_cpu_datapath;
   logic clk = 1'b0;
   logic clear;

   cpu_datapath_if io ();

   cpu_datapath dut (
      .Clock (clk),
      .Clear (clear),
      .io    (io)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [31:0] val;
   } exp_t;

   typedef struct {
      string       nm;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
   } alu_vec_t;

   exp_t     sb[$];
   alu_vec_t vecs[17];
   int       n_run  = 0;
   int       n_fail = 0;

   task automatic idle_ctl();
      io.IncPC = 0; io.CONin = 0;
      io.RAM_write = 0; io.MDR_enable = 0; io.MDRout = 0; io.MAR_enable = 0;
      io.IR_enable = 0; io.MDR_read = 0;
      io.Gra = 0; io.Grb = 0; io.Grc = 0;
      io.HI_enable = 0; io.LO_enable = 0; io.ZHighIn = 0; io.ZLowIn = 0;
      io.Y_enable = 0; io.PC_enable = 0; io.OutPort_enable = 0;
      io.InPortout = 0; io.PCout = 0; io.Yout = 0; io.ZLowout = 0; io.ZHighout = 0;
      io.LOout = 0; io.HIout = 0; io.BAout = 0; io.Cout = 0;
      io.R_in = 0; io.R_out = 0; io.Cin = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle_ctl();
      clear = 1'b0;
   endtask

   // InPort samples every edge, so a value needs one cycle before it can drive the bus.
   task automatic in_to(input logic [31:0] v);
      io.InPort_input = v;
      step();
      io.InPortout = 1'b1;
   endtask

   task automatic check_out();
      exp_t e;
      n_run++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got %h", io.OutPort_output);
         return;
      end
      e = sb.pop_front();
      if (io.OutPort_output !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", e.nm, io.OutPort_output, e.val);
      end
   endtask

   // Caller raises the source strobe first; the bus lands in OutPort.
   task automatic observe(input string nm, input logic [31:0] v);
      exp_t e;
      e.nm  = nm;
      e.val = v;
      sb.push_back(e);
      io.OutPort_enable = 1'b1;
      step();
      check_out();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      vecs[0]  = '{"add",      5'b00011, 32'h00000005, 32'h00000007, 32'h0000000C, 32'h00000000};
      vecs[1]  = '{"sub",      5'b00100, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 32'h00000000};
      vecs[2]  = '{"mul",      5'b01110, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'hFFFFFFFF};
      vecs[3]  = '{"div",      5'b01111, 32'h00000007, 32'h00000002, 32'h00000003, 32'h00000001};
      vecs[4]  = '{"div0",     5'b01111, 32'h00000007, 32'h00000000, 32'h00000000, 32'h00000007};
      vecs[5]  = '{"div_neg",  5'b01111, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF};
      vecs[6]  = '{"ror",      5'b00111, 32'h80000001, 32'h00000001, 32'hC0000000, 32'h00000000};
      vecs[7]  = '{"shr",      5'b00101, 32'h80000001, 32'h00000001, 32'h40000000, 32'h00000000};
      vecs[8]  = '{"shl",      5'b00110, 32'h80000001, 32'h00000001, 32'h00000002, 32'h00000000};
      vecs[9]  = '{"rol",      5'b01000, 32'h80000001, 32'h00000001, 32'h00000003, 32'h00000000};
      vecs[10] = '{"and",      5'b01001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h00000000};
      vecs[11] = '{"or",       5'b01010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h00000000};
      vecs[12] = '{"neg",      5'b10000, 32'h00000009, 32'h00000005, 32'hFFFFFFFB, 32'h00000000};
      vecs[13] = '{"not",      5'b10001, 32'h00000009, 32'h0000FFFF, 32'hFFFF0000, 32'h00000000};
      vecs[14] = '{"addi_wrap",5'b01011, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h00000000};
      vecs[15] = '{"shr_b36",  5'b00101, 32'h80000000, 32'h00000024, 32'h08000000, 32'h00000000};
      vecs[16] = '{"pass_b",   5'b11111, 32'h00000099, 32'h00001234, 32'h00001234, 32'h00000000};

      idle_ctl();
      io.InPort_input = '0;
      io.Mdatain      = 32'hDEADBEEF;
      clear           = 1'b0;
      do_clear();

      // Dirty every register so the next Clear has something to erase.
      in_to(32'h22);       io.Gra = 1; io.R_in = 1;        step();
      in_to(32'h55);       io.PC_enable = 1;               step();
      in_to(32'h33);       io.Y_enable = 1;                step();
      in_to(32'h44);       io.MDR_enable = 1;              step();
      in_to(32'h66);       io.HI_enable = 1; io.LO_enable = 1; step();
      in_to(32'h77);       io.ZLowIn = 1; io.ZHighIn = 1;  step();
      in_to(32'h00800000); io.IR_enable = 1;               step();
      in_to(32'h11);       io.Gra = 1; io.R_in = 1;        step();
      in_to(32'h99);       io.OutPort_enable = 1;          step();
      do_clear();

      e.nm = "outport_reset"; e.val = 32'h0; sb.push_back(e);
      check_out();
      io.PCout = 1;            observe("pc_reset", 32'h0);
      io.MDRout = 1;           observe("mdr_reset", 32'h0);
      io.Yout = 1;             observe("y_reset", 32'h0);
      io.HIout = 1;            observe("hi_reset", 32'h0);
      io.LOout = 1;            observe("lo_reset", 32'h0);
      io.ZLowout = 1;          observe("zlo_reset", 32'h0);
      io.Gra = 1; io.R_out = 1; observe("r_sel_reset", 32'h0);

      // RAM write/read at two addresses, including aliasing of MAR upper bits.
      in_to(32'h12);   io.MAR_enable = 1; step();
      in_to(32'hABCD); io.MDR_enable = 1; step();
      io.RAM_write = 1; step();
      io.MDRout = 1;   observe("mdr_bus_load", 32'hABCD);
      in_to(32'h13);   io.MAR_enable = 1; step();
      in_to(32'h5555); io.MDR_enable = 1; step();
      io.RAM_write = 1; step();
      in_to(32'h0);    io.MDR_enable = 1; step();
      io.MDRout = 1;   observe("mdr_cleared", 32'h0);
      in_to(32'h12);   io.MAR_enable = 1; step();
      io.MDR_read = 1; io.MDR_enable = 1; step();
      io.MDRout = 1;   observe("ram_rd_12", 32'hABCD);
      in_to(32'h13);   io.MAR_enable = 1; step();
      io.MDR_read = 1; io.MDR_enable = 1; step();
      io.MDRout = 1;   observe("ram_rd_13", 32'h5555);
      in_to(32'h212);  io.MAR_enable = 1; step();
      io.MDR_read = 1; io.MDR_enable = 1; step();
      io.MDRout = 1;   observe("ram_rd_alias", 32'hABCD);

      // Fetch/execute ldi; the Clear in between must not disturb RAM[0].
      in_to(32'h0);        io.MAR_enable = 1; step();
      in_to(32'h08800007); io.MDR_enable = 1; step();
      io.RAM_write = 1; step();
      do_clear();
      in_to(32'h77); io.Gra = 1; io.R_in = 1; step();
      io.PCout = 1; io.MAR_enable = 1; io.IncPC = 1; step();
      io.PCout = 1; observe("pc_inc", 32'h1);
      io.MDR_read = 1; io.MDR_enable = 1; step();
      io.MDRout = 1; observe("fetch_mdr", 32'h08800007);
      io.MDRout = 1; io.IR_enable = 1; step();
      io.Grb = 1; io.BAout = 1; io.Y_enable = 1; step();
      io.Yout = 1; observe("y_baout_r0", 32'h0);
      io.Grb = 1; io.R_out = 1; observe("r0_rout", 32'h77);
      io.Cout = 1; io.ZLowIn = 1; step();
      io.ZLowout = 1; io.Gra = 1; io.R_in = 1; step();
      io.Gra = 1; io.R_out = 1; observe("ldi_r1", 32'h7);
      io.Gra = 1; io.R_out = 1; io.PCout = 1; observe("bus_priority", 32'h7);

      // C field sign extension.
      in_to(32'hF8040001); io.IR_enable = 1; step();
      io.Cout = 1; observe("c_sext", 32'hFFFC0001);

      // ALU vector table.
      for (int i = 0; i < 17; i++) begin
         in_to({vecs[i].op, 27'd0}); io.IR_enable = 1; step();
         in_to(vecs[i].a);           io.Y_enable = 1;  step();
         in_to(vecs[i].b);           io.ZLowIn = 1; io.ZHighIn = 1; step();
         io.ZLowout = 1;  observe({vecs[i].nm, "_lo"}, vecs[i].lo);
         io.ZHighout = 1; observe({vecs[i].nm, "_hi"}, vecs[i].hi);
      end

      // ZHighIn alone leaves the low half from the previous result.
      in_to(32'h70000000); io.IR_enable = 1; step();
      in_to(32'hFFFFFFFE); io.Y_enable = 1;  step();
      in_to(32'h3);        io.ZHighIn = 1;   step();
      io.ZHighout = 1; observe("zhi_only_hi", 32'hFFFFFFFF);
      io.ZLowout = 1;  observe("zhi_only_lo", 32'h00001234);

      // Branch conditions gating PC loads.
      in_to(32'h90000000); io.IR_enable = 1; step();
      in_to(32'h0);        io.CONin = 1;     step();
      in_to(32'h20);       io.PC_enable = 1; step();
      io.PCout = 1; observe("br_eq_taken", 32'h20);
      in_to(32'h90080000); io.IR_enable = 1; step();
      in_to(32'h0);        io.CONin = 1;     step();
      in_to(32'h40);       io.PC_enable = 1; step();
      io.PCout = 1; observe("br_ne_not_taken", 32'h20);
      in_to(32'h40); io.PC_enable = 1; io.IncPC = 1; step();
      io.PCout = 1; observe("incpc_wins", 32'h21);
      in_to(32'h90100000); io.IR_enable = 1; step();
      in_to(32'hFFFFFFFF); io.CONin = 1;     step();
      in_to(32'h50);       io.PC_enable = 1; step();
      io.PCout = 1; observe("br_ge_not_taken", 32'h21);
      in_to(32'h90180000); io.IR_enable = 1; step();
      in_to(32'h80000000); io.CONin = 1;     step();
      in_to(32'h60);       io.PC_enable = 1; step();
      io.PCout = 1; observe("br_lt_taken", 32'h60);
      in_to(32'h90080000); io.IR_enable = 1; step();
      in_to(32'h0);        io.CONin = 1;     step();
      in_to(32'h18000000); io.IR_enable = 1; step();
      in_to(32'h70);       io.PC_enable = 1; step();
      io.PCout = 1; observe("nonbr_ignores_con", 32'h70);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
